// File: rtl/interval_meter.sv
// Measures the cycle distance between a start pulse and a stop pulse and
// hands the saturated count to a consumer over a valid/ready port.
module interval_meter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             result_valid,
  input  logic             result_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEAS = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_overflow, w_overflow_nxt;

  // Saturating increment: returns {overflow_flag, count}; the count sticks at max.
  function automatic logic [WIDTH:0] sat_inc(input logic [WIDTH-1:0] c,
                                             input logic ovf_in);
    if (c == CNT_MAX) sat_inc = {1'b1, c};
    else              sat_inc = {ovf_in, c + CNT_ONE};
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= CNT_ZERO;
      r_ovf      <= 1'b0;
      r_result   <= CNT_ZERO;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ovf      <= w_ovf_nxt;
      r_result   <= w_result_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_ovf_nxt      = r_ovf;
    w_result_nxt   = r_result;
    w_overflow_nxt = r_overflow;
    case (r_state)
      S_IDLE: begin
        if (start && stop) begin
          w_state_nxt    = S_HOLD;
          w_result_nxt   = CNT_ZERO;
          w_overflow_nxt = 1'b0;
        end else if (start) begin
          w_state_nxt = S_MEAS;
          w_cnt_nxt   = CNT_ONE;
          w_ovf_nxt   = 1'b0;
        end
      end
      S_MEAS: begin
        // A restart outranks a coincident stop.
        if (start) begin
          w_cnt_nxt = CNT_ONE;
          w_ovf_nxt = 1'b0;
        end else if (stop) begin
          w_state_nxt    = S_HOLD;
          w_result_nxt   = r_cnt;
          w_overflow_nxt = r_ovf;
        end else begin
          {w_ovf_nxt, w_cnt_nxt} = sat_inc(r_cnt, r_ovf);
        end
      end
      S_HOLD: begin
        if (result_ready) begin
          if (start) begin
            w_state_nxt = S_MEAS;
            w_cnt_nxt   = CNT_ONE;
            w_ovf_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy         = (r_state == S_MEAS);
  assign result_valid = (r_state == S_HOLD);
  assign result       = r_result;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_interval_meter.sv
// Randomized and directed checks of interval_meter against a timestamp-based
// reference model (interval = stop cycle minus start cycle, saturated).
module tb_interval_meter;

  localparam int WIDTH = 8;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             result_ready = 1'b0;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             result_valid;

  interval_meter #(.WIDTH(WIDTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start        (start),
    .stop         (stop),
    .busy         (busy),
    .result       (result),
    .overflow     (overflow),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference model state: is a measurement open, when did it start,
  // and is a result waiting for the consumer.
  bit m_meas = 1'b0;
  bit m_pend = 1'b0;
  int m_t0   = 0;
  int m_res  = 0;
  int m_ovf  = 0;
  int cyc    = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_update(input bit s, input bit p, input bit r, input bit rs);
    int d;
    if (rs) begin
      m_meas = 1'b0;
      m_pend = 1'b0;
    end else if (m_pend) begin
      if (r) begin
        m_pend = 1'b0;
        if (s) begin
          m_meas = 1'b1;
          m_t0   = cyc;
        end
      end
    end else if (m_meas) begin
      if (s) begin
        m_t0 = cyc;
      end else if (p) begin
        d      = cyc - m_t0;
        m_meas = 1'b0;
        m_pend = 1'b1;
        m_res  = (d > MAXV) ? MAXV : d;
        m_ovf  = (d > MAXV) ? 1 : 0;
      end
    end else if (s) begin
      if (p) begin
        m_pend = 1'b1;
        m_res  = 0;
        m_ovf  = 0;
      end else begin
        m_meas = 1'b1;
        m_t0   = cyc;
      end
    end
    cyc++;
  endtask

  task automatic step(input bit s, input bit p, input bit r, input bit rs);
    start        = s;
    stop         = p;
    result_ready = r;
    rst_i        = rs;
    @(posedge clk_i);
    model_update(s, p, r, rs);
    #1;
    check_val("busy", 32'(busy), 32'(m_meas));
    check_val("result_valid", 32'(result_valid), 32'(m_pend));
    if (m_pend) begin
      check_val("result", 32'(result), 32'(m_res));
      check_val("overflow", 32'(overflow), 32'(m_ovf));
    end
    if (rs) begin
      check_val("rst_result", 32'(result), 32'd0);
      check_val("rst_overflow", 32'(overflow), 32'd0);
    end
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, r, 1'b0);
  endtask

  initial begin
    int tcnt;
    bit done;
    bit rs, s, p, r;

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Basic interval of 25 cycles.
    idle(9, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(24, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("tp_res25", 32'(result), 32'd25);
    check_val("tp_ovf25", 32'(overflow), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("tp_valid_drop", 32'(result_valid), 32'd0);

    // Coincident start+stop in idle, then lone stop in idle.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("zero_res", 32'(result), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("lone_stop_busy", 32'(busy), 32'd0);
    idle(2, 1'b1);

    // Restart behaviour.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(6, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("restart_res7", 32'(result), 32'd7);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(19, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_val("ss_restart_valid", 32'(result_valid), 32'd0);
    idle(2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("restart_res3", 32'(result), 32'd3);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Saturation boundaries.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(254, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("sat255_res", 32'(result), 32'd255);
    check_val("sat255_ovf", 32'(overflow), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(299, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("sat300_res", 32'(result), 32'd255);
    check_val("sat300_ovf", 32'(overflow), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("after_sat_res", 32'(result), 32'd4);
    check_val("after_sat_ovf", 32'(overflow), 32'd0);

    // Backpressure: pulses during hold ignored, then ready+start restarts.
    for (int i = 0; i < 6; i++) begin
      step(1'(i % 2), 1'(i % 3 == 0), 1'b0, 1'b0);
      check_val("bp_hold_res", 32'(result), 32'd4);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("bp_new_res", 32'(result), 32'd3);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Loopback with a countdown timer loaded with 17.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    tcnt = 17;
    done = 1'b0;
    while (!done) begin
      tcnt--;
      done = (tcnt == 0);
      step(1'b0, done, 1'b1, 1'b0);
    end
    check_val("loopback_res", 32'(result), 32'd17);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-measurement discards it.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(5, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("mid_rst_valid", 32'(result_valid), 32'd0);
    idle(3, 1'b1);

    // Random traffic: short intervals, then long ones to reach saturation.
    for (int i = 0; i < 2000; i++) begin
      s  = ($urandom_range(0, 19) == 0);
      p  = ($urandom_range(0, 14) == 0);
      r  = ($urandom_range(0, 9) < 7);
      rs = ($urandom_range(0, 499) == 0);
      step(s, p, r, rs);
    end
    for (int i = 0; i < 1500; i++) begin
      s  = ($urandom_range(0, 299) == 0);
      p  = ($urandom_range(0, 249) == 0);
      r  = ($urandom_range(0, 9) < 8);
      step(s, p, r, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
